// File: rtl/dma_irq_coalesce.sv
// ============================================================================
// Module      : dma_irq_coalesce
// Description : Two-channel (read/write) DMA completion interrupt coalescer.
//               Optional per-channel timeout enabled by DMA_IRQ_COALESCE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_irq_coalesce #(
   parameter int CntWidth   = 8,
   parameter int TimerWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  r_done_i,
   input  logic                  w_done_i,
   input  logic                  en_i,
   input  logic [CntWidth-1:0]   threshold_i,
   input  logic [TimerWidth-1:0] timeout_i,
   input  logic [1:0]            ack_i,
   output logic [1:0]            irq_o,
   output logic [2*CntWidth-1:0] count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FIRE  = 2'd2
   } state_e;

   localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   logic [1:0]          done;
   logic [CntWidth-1:0] thr_eff;

   assign done    = {w_done_i, r_done_i};
   assign thr_eff = (threshold_i == '0) ? CntOne : threshold_i;

`ifndef DMA_IRQ_COALESCE_TIMEOUT_EN
   logic unused_timeout;
   assign unused_timeout = ^timeout_i;
`endif

   for (genvar c = 0; c < 2; c++) begin : g_chan
      state_e              state_q, state_d;
      logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
      logic                irq_q;
      logic                pulse;
      logic                to_hit;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
      logic [TimerWidth-1:0] timer_q, timer_d;
`endif

      assign pulse   = done[c] & en_i;
      assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
      assign to_hit = (timeout_i != '0) && ((timer_q + TimerWidth'(1)) == timeout_i);
`else
      assign to_hit = 1'b0;
`endif

      always_comb begin
         state_d = state_q;
         cnt_d   = pulse ? cnt_inc : cnt_q;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
         timer_d = timer_q;
`endif
         unique case (state_q)
            IDLE: begin
               if (pulse) begin
                  cnt_d   = CntOne;
                  state_d = (thr_eff == CntOne) ? FIRE : ACCUM;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
                  timer_d = '0;
`endif
               end
            end
            ACCUM: begin
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
               timer_d = timer_q + TimerWidth'(1);
`endif
               // Compare the post-update count so a lowered threshold also fires.
               if ((cnt_d >= thr_eff) || to_hit) begin
                  state_d = FIRE;
               end
            end
            FIRE: begin
               if (ack_i[c]) begin
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
                  timer_d = '0;
`endif
                  if (pulse) begin
                     cnt_d   = CntOne;
                     state_d = (thr_eff == CntOne) ? FIRE : ACCUM;
                  end else begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
            timer_q <= '0;
`endif
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= (state_d == FIRE);
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
            timer_q <= timer_d;
`endif
         end
      end

      assign irq_o[c]                          = irq_q;
      assign count_o[c*CntWidth +: CntWidth]   = cnt_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_irq_coalesce.sv
// ============================================================================
// Module      : tb_dma_irq_coalesce
// Description : Directed plus random bench for dma_irq_coalesce against a
//               count/age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_irq_coalesce;

   localparam int CW     = 8;
   localparam int TW     = 16;
   localparam int CMAX   = (1 << CW) - 1;
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
   localparam bit TO_EN  = 1'b1;
`else
   localparam bit TO_EN  = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          r_done_i, w_done_i, en_i;
   logic [CW-1:0] threshold_i;
   logic [TW-1:0] timeout_i;
   logic [1:0]    ack_i;
   logic [1:0]    irq_o;
   logic [2*CW-1:0] count_o;

   int nchecks = 0;
   int nerrors = 0;

   int m_cnt [2];
   bit m_irq [2];
   int m_age [2];

   dma_irq_coalesce #(.CntWidth(CW), .TimerWidth(TW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .r_done_i    (r_done_i),
      .w_done_i    (w_done_i),
      .en_i        (en_i),
      .threshold_i (threshold_i),
      .timeout_i   (timeout_i),
      .ack_i       (ack_i),
      .irq_o       (irq_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_cnt[c] = 0;
         m_irq[c] = 1'b0;
         m_age[c] = 0;
      end
   endtask

   // Interrupt is pending, or the new count meets the threshold, or the
   // accumulation age reaches the programmed timeout.
   task automatic model_step(input bit [1:0] done, input bit [1:0] ack);
      for (int c = 0; c < 2; c++) begin
         int  p, teff, ncnt;
         bit  accum, hit, nirq;
         p     = (done[c] && en_i) ? 1 : 0;
         teff  = (threshold_i == 0) ? 1 : int'(threshold_i);
         accum = !m_irq[c] && (m_cnt[c] > 0);
         if (m_irq[c] && ack[c]) ncnt = p;
         else                    ncnt = (m_cnt[c] + p > CMAX) ? CMAX : m_cnt[c] + p;
         hit   = TO_EN && accum && (timeout_i != 0) &&
                 (((m_age[c] + 1) % (1 << TW)) == int'(timeout_i));
         nirq  = (m_irq[c] && !ack[c]) || (ncnt > 0 && ncnt >= teff) || hit;
         m_age[c] = accum ? m_age[c] + 1 : 0;
         m_cnt[c] = ncnt;
         m_irq[c] = nirq;
      end
   endtask

   task automatic cycle(input bit [1:0] done, input bit [1:0] ack);
      r_done_i = done[0];
      w_done_i = done[1];
      ack_i    = ack;
      model_step(done, ack);
      @(posedge clk_i);
      @(negedge clk_i);
      r_done_i = 1'b0;
      w_done_i = 1'b0;
      ack_i    = 2'b00;
      chk("model_irq",   32'(irq_o),   32'({m_irq[1], m_irq[0]}));
      chk("model_count", 32'(count_o), 32'({m_cnt[1][CW-1:0], m_cnt[0][CW-1:0]}));
   endtask

   initial begin
      rst_ni      = 1'b0;
      r_done_i    = 1'b0;
      w_done_i    = 1'b0;
      en_i        = 1'b1;
      threshold_i = 8'd4;
      timeout_i   = '0;
      ack_i       = 2'b00;
      model_reset();
      repeat (2) @(negedge clk_i);
      chk("reset_irq",   32'(irq_o),   32'h0);
      chk("reset_count", 32'(count_o), 32'h0);
      rst_ni = 1'b1;
      repeat (2) cycle(2'b00, 2'b00);

      // Threshold 4, pulses every other cycle.
      for (int i = 0; i < 4; i++) begin
         cycle(2'b01, 2'b00);
         if (i < 3) begin
            chk("thr4_no_early_irq", 32'(irq_o[0]), 32'h0);
            cycle(2'b00, 2'b00);
         end
      end
      chk("thr4_irq",   32'(irq_o[0]),      32'h1);
      chk("thr4_count", 32'(count_o[7:0]),  32'd4);
      cycle(2'b00, 2'b10);
      chk("ack_wrong_chan", 32'(irq_o[0]),  32'h1);
      cycle(2'b00, 2'b01);
      chk("ack_irq",   32'(irq_o),   32'h0);
      chk("ack_count", 32'(count_o), 32'h0);

      // Ack coincident with a new pulse restarts accumulation.
      threshold_i = 8'd2;
      cycle(2'b10, 2'b00);
      cycle(2'b10, 2'b00);
      chk("thr2_irq", 32'(irq_o[1]), 32'h1);
      cycle(2'b10, 2'b10);
      chk("ackpulse_irq",   32'(irq_o[1]),       32'h0);
      chk("ackpulse_count", 32'(count_o[15:8]),  32'd1);
      cycle(2'b10, 2'b00);
      chk("ackpulse_refire", 32'(irq_o[1]), 32'h1);
      cycle(2'b00, 2'b10);

      // Threshold 0 acts as 1; disabled pulses are masked.
      threshold_i = 8'd0;
      cycle(2'b11, 2'b00);
      chk("thr0_both_irq", 32'(irq_o), 32'h3);
      en_i = 1'b0;
      repeat (5) cycle(2'b11, 2'b00);
      chk("en_off_count", 32'(count_o), 32'h0101);
      chk("en_off_irq",   32'(irq_o),   32'h3);
      en_i = 1'b1;
      cycle(2'b00, 2'b11);

      // Lowering the threshold to the current count fires without a pulse.
      threshold_i = 8'd5;
      repeat (3) cycle(2'b01, 2'b00);
      cycle(2'b00, 2'b01);
      chk("accum_ack_ignored", 32'(count_o[7:0]), 32'd3);
      threshold_i = 8'd3;
      cycle(2'b00, 2'b00);
      chk("thr_lowered_irq", 32'(irq_o[0]), 32'h1);
      cycle(2'b00, 2'b01);

      threshold_i = 8'd8;
      timeout_i   = 16'd50;
      cycle(2'b10, 2'b00);
`ifdef DMA_IRQ_COALESCE_TIMEOUT_EN
      repeat (49) cycle(2'b00, 2'b00);
      chk("timeout_not_yet", 32'(irq_o), 32'h0);
      cycle(2'b00, 2'b00);
      chk("timeout_irq",   32'(irq_o),          32'h2);
      chk("timeout_count", 32'(count_o[15:8]),  32'd1);
      cycle(2'b00, 2'b10);
`else
      repeat (60) cycle(2'b00, 2'b00);
      chk("no_timeout_irq", 32'(irq_o), 32'h0);
      repeat (7) cycle(2'b10, 2'b00);
      chk("no_timeout_thr_irq", 32'(irq_o), 32'h2);
      cycle(2'b00, 2'b10);
`endif

      // Saturation, then asynchronous reset while firing.
      threshold_i = 8'd255;
      timeout_i   = '0;
      repeat (300) cycle(2'b01, 2'b00);
      chk("sat_count", 32'(count_o[7:0]), 32'd255);
      chk("sat_irq",   32'(irq_o[0]),     32'h1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_irq",   32'(irq_o),   32'h0);
      chk("async_rst_count", 32'(count_o), 32'h0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) cycle(2'b00, 2'b00);
      chk("post_rst_irq", 32'(irq_o), 32'h0);

      // Random traffic.
      threshold_i = 8'($urandom_range(0, 6));
      timeout_i   = 16'($urandom_range(0, 20));
      for (int i = 0; i < 2000; i++) begin
         bit [1:0] d, a;
         if ($urandom_range(0, 49) == 0) threshold_i = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 99) == 0) timeout_i   = 16'($urandom_range(0, 20));
         en_i = ($urandom_range(0, 9) != 0);
         d    = 2'($urandom);
         a    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
         cycle(d, a);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dma_irq_coalesce.md
DMA_IRQ_COALESCE -- requirements
Module: dma_irq_coalesce

Interface
- REQ-001: Parameter CntWidth, default 8: width of each per-channel completion counter.
- REQ-002: Parameter TimerWidth, default 16: width of each per-channel timeout timer and of the timeout configuration.
- REQ-003: clk_i  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst_ni  input  1  reset; asynchronous, active-low.
- REQ-005: r_done_i  input  1  single-cycle pulse per completed read transfer; drives channel 0.
- REQ-006: w_done_i  input  1  single-cycle pulse per completed write transfer; drives channel 1.
- REQ-007: en_i  input  1  coalescing enable; when low, done pulses are ignored.
- REQ-008: threshold_i  input  CntWidth  completion count that raises the interrupt; value 0 behaves as 1.
- REQ-009: timeout_i  input  TimerWidth  cycles in ACCUM before forced interrupt; 0 disables the timeout.
- REQ-010: ack_i  input  2  per-channel acknowledge, W1C-style pulse from the register file; bit 0 read, bit 1 write.
- REQ-011: irq_o  output  2  registered coalesced interrupts; bit 0 read, bit 1 write.
- REQ-012: count_o  output  2*CntWidth  per-channel pending count; channel 0 in bits [CntWidth-1:0].

Function
- REQ-013: The two channels SHALL be fully independent instances of the same FSM; simultaneous events on both channels SHALL not interact.
- REQ-014: Each channel FSM SHALL have states IDLE (cnt=0, irq low), ACCUM (cnt>0, irq low), FIRE (irq high).
- REQ-015: A qualified done pulse (done & en_i) SHALL increment cnt by 1, saturating at 2^CntWidth-1 in every state.
- REQ-016: In IDLE, a qualified pulse SHALL move to ACCUM with cnt=1 and timer=0; if the effective threshold is 1, the FSM SHALL instead go directly to FIRE.
- REQ-017: In ACCUM, the FSM SHALL move to FIRE in the cycle after the updated cnt is greater than or equal to the effective threshold.
- REQ-018: irq_o[c] SHALL be a flop equal to (state==FIRE); the pulse that reaches the threshold in cycle N yields irq_o high in cycle N+1.
- REQ-019: A threshold_i lowered to or below the current cnt while in ACCUM SHALL cause FIRE on the next cycle without a further pulse.
- REQ-020: In FIRE, qualified pulses SHALL continue to count (saturating); irq_o SHALL stay high until ack.
- REQ-021: ack_i[c] in FIRE SHALL clear cnt and timer and move to IDLE; ack with a coincident qualified pulse SHALL move to ACCUM with cnt=1 (or FIRE if the effective threshold is 1).
- REQ-022: ack_i[c] in IDLE or ACCUM SHALL have no effect.
- REQ-023: count_o SHALL reflect registered cnt (zero-latency view of the flops).
- REQ-024: Deasserting en_i SHALL not alter state, cnt, timer or irq_o; it only masks new pulses.

Reset
- REQ-025: On rst_ni low, both channels SHALL asynchronously enter IDLE with cnt=0, timer=0, irq_o=2'b00, count_o=0.
- REQ-026: Reset asserted mid-ACCUM or in FIRE SHALL discard pending counts; no interrupt SHALL be emitted on reset release.

Configuration
- REQ-027: Macro DMA_IRQ_COALESCE_TIMEOUT_EN SHALL gate the timeout feature.
- REQ-028: With the macro defined, in ACCUM the timer SHALL increment every cycle, and when timeout_i!=0 and timer+1 == timeout_i the FSM SHALL enter FIRE on the next edge (irq high exactly timeout_i cycles after entering ACCUM); threshold and timeout reaching together yields a single FIRE.
- REQ-029: Without the macro, timer flops SHALL not exist, timeout_i SHALL be ignored, and FIRE SHALL be reached only via threshold.

Verification
- REQ-030: threshold=4, timeout=0, en=1; 4 r_done pulses on cycles 10,12,14,16 -> irq_o[0] rises cycle 17, count_o[7:0]=4; ack_i[0] cycle 20 -> irq_o[0]=0, count=0 cycle 21.
- REQ-031: (TIMEOUT_EN) threshold=8, timeout=50; one w_done pulse cycle 5 -> irq_o[1] rises cycle 56, count_o[15:8]=1; irq_o[0] stays 0.
- REQ-032: Threshold=2; ack_i[1] and w_done coincident in FIRE -> next cycle irq_o[1]=0, state ACCUM, count=1; one more pulse -> irq_o[1] high one cycle later.
- REQ-033: Threshold=0; r_done and w_done same cycle 3 -> both irq_o bits high cycle 4; en_i=0 with 5 further pulses -> counts unchanged at 1.
- REQ-034: CntWidth=8, threshold=255, 300 pulses -> count saturates at 255, irq high; rst_ni pulsed low in FIRE -> irq_o=0 and count=0 immediately, no irq after release.
